// File: rtl/rx_gain_pkg.sv
// Shared definitions for the 3-wire gain/attenuator serial link (TX and RX sides).
package rx_gain_pkg;

  localparam int unsigned GAIN_WORD_BITS  = 16;
  localparam int unsigned GAIN_ADDR_BITS  = 3;
  localparam int unsigned GAIN_VALUE_BITS = 8;

  localparam int unsigned GAIN_VALUE_LSB = 0;
  localparam int unsigned GAIN_VALUE_MSB = 7;
  localparam int unsigned GAIN_ADDR_LSB  = 8;
  localparam int unsigned GAIN_ADDR_MSB  = 10;
  localparam int unsigned GAIN_PAD_LSB   = 11;
  localparam int unsigned GAIN_PAD_MSB   = 15;
  localparam int unsigned GAIN_CODE_LSB  = 1;
  localparam int unsigned GAIN_CODE_MSB  = 6;

  typedef struct packed {
    logic [4:0]                 pad;
    logic [GAIN_ADDR_BITS-1:0]  addr;
    logic [GAIN_VALUE_BITS-1:0] value;
  } rx_gain_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT,
    ST_WAIT_LE
  } rx_gain_state_t;

  // A word is legal when the pad is zero and the value carries a clean 6-bit code.
  function automatic logic gain_word_legal(input rx_gain_word_t w);
    return (w.pad == '0) && !w.value[GAIN_VALUE_MSB] && !w.value[GAIN_VALUE_LSB];
  endfunction

endpackage

// File: rtl/rx_gain_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses for one async input.
// level_o is the synchronised level delayed to line up with the pulses.
module rx_gain_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain, delayed copy and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_o <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_o <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level_o = prev_q;

endmodule

// File: rtl/rx_gain_serial_rx.sv
// Receive end of the 3-wire gain serial link: LSB-first 16-bit capture on
// serial-clock rises, commit on LE rise, 8-entry bank of last-written values.
module rx_gain_serial_rx
  import rx_gain_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gain_si_i,
  input  logic        gain_clk_i,
  input  logic        gain_le_i,
  input  logic [2:0]  bank_rd_addr_i,
  output logic [15:0] word_o,
  output logic [2:0]  addr_o,
  output logic [7:0]  value_o,
  output logic [5:0]  gain_o,
  output logic        word_valid_o,
  output logic        frame_err_o,
  output logic [7:0]  bank_rd_data_o
);

  localparam int unsigned        TO_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [4:0]         CNT_SAT = 5'd17;
  localparam logic [4:0]         CNT_FULL = 5'(GAIN_WORD_BITS);

  logic si_lvl, si_rise_unused, si_fall_unused;
  logic clk_lvl_unused, clk_rise, clk_fall_unused;
  logic le_lvl, le_rise, le_fall;

  rx_gain_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_si (
    .clk(clk), .rst_n(rst_n), .async_i(gain_si_i),
    .level_o(si_lvl), .rise_o(si_rise_unused), .fall_o(si_fall_unused)
  );

  rx_gain_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .async_i(gain_clk_i),
    .level_o(clk_lvl_unused), .rise_o(clk_rise), .fall_o(clk_fall_unused)
  );

  rx_gain_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk(clk), .rst_n(rst_n), .async_i(gain_le_i),
    .level_o(le_lvl), .rise_o(le_rise), .fall_o(le_fall)
  );

  rx_gain_state_t     state_q, state_n;
  logic [15:0]        shift_q;
  logic [4:0]         bit_cnt_q;
  logic [TO_W-1:0]    idle_cnt_q;
  logic [15:0]        word_q;
  logic [7:0]         bank_q [8];
  rx_gain_word_t      shift_w;

  logic do_shift, do_clear, commit_ok, commit_err, frame_ok;

  assign shift_w  = rx_gain_word_t'(shift_q);
  assign frame_ok = (bit_cnt_q == CNT_FULL) && gain_word_legal(shift_w);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Next state and datapath controls. A shift and an LE rise in the same
  // cycle both take effect, so COMMIT sees the updated bit count.
  always_comb begin
    state_n    = state_q;
    do_shift   = 1'b0;
    do_clear   = 1'b0;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clk_rise) begin
          do_shift = 1'b1;
          state_n  = ST_SHIFT;
        end
        if (le_rise) state_n = ST_COMMIT;
      end
      ST_SHIFT: begin
        if (clk_rise) do_shift = 1'b1;
        if (le_rise) begin
          state_n = ST_COMMIT;
        end else if (!clk_rise && idle_cnt_q == TO_LAST) begin
          state_n  = ST_IDLE;
          do_clear = 1'b1;
        end
      end
      ST_COMMIT: begin
        commit_ok  = frame_ok;
        commit_err = !frame_ok;
        state_n    = ST_WAIT_LE;
      end
      ST_WAIT_LE: begin
        if (le_fall || !le_lvl) begin
          state_n  = ST_IDLE;
          do_clear = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Shift register, saturating bit counter and serial-clock idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      if (do_clear) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (do_shift) begin
        shift_q <= {si_lvl, shift_q[15:1]};
        if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (state_q == ST_SHIFT && !clk_rise && !do_clear) idle_cnt_q <= idle_cnt_q + 1'b1;
      else                                               idle_cnt_q <= '0;
    end
  end

  // Commit results: output word, bank write and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      word_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) bank_q[i] <= '0;
    end else begin
      word_valid_o <= commit_ok;
      frame_err_o  <= commit_err;
      if (commit_ok) begin
        word_q               <= shift_q;
        bank_q[shift_w.addr] <= shift_w.value;
      end
    end
  end

  assign word_o         = word_q;
  assign addr_o         = word_q[GAIN_ADDR_MSB:GAIN_ADDR_LSB];
  assign value_o        = word_q[GAIN_VALUE_MSB:GAIN_VALUE_LSB];
  assign gain_o         = word_q[GAIN_CODE_MSB:GAIN_CODE_LSB];
  assign bank_rd_data_o = bank_q[bank_rd_addr_i];

endmodule

// File: tb/tb_rx_gain_serial_rx.sv
// Self-checking bench for rx_gain_serial_rx: directed table, timeout/latency,
// randomized frames against a word/bank reference model, reset cases.
module tb_rx_gain_serial_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        si = 1'b0, sclk = 1'b0, le = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] word_o;
  logic [2:0]  addr_o;
  logic [7:0]  value_o;
  logic [5:0]  gain_o;
  logic        word_valid_o, frame_err_o;
  logic [7:0]  bank_rd_data_o;

  rx_gain_serial_rx #(.SYNC_STAGES(SYNC), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .gain_si_i(si), .gain_clk_i(sclk), .gain_le_i(le),
    .bank_rd_addr_i(rd_addr),
    .word_o(word_o), .addr_o(addr_o), .value_o(value_o), .gain_o(gain_o),
    .word_valid_o(word_valid_o), .frame_err_o(frame_err_o),
    .bank_rd_data_o(bank_rd_data_o)
  );

  always #5 clk = ~clk;

  // Running pulse totals, sampled on the falling edge.
  int n_valid = 0, n_err = 0, n_both = 0;
  always @(negedge clk) begin
    if (word_valid_o) n_valid++;
    if (frame_err_o)  n_err++;
    if (word_valid_o && frame_err_o) n_both++;
  end

  int checks = 0, failures = 0;

  // Reference model: last accepted word and the value bank.
  logic [15:0] m_word;
  logic [7:0]  m_bank [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_clear();
    m_word = '0;
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
  endfunction

  // Frame is taken only if exactly 16 bits arrived and the fields are legal.
  function automatic void model_frame(input logic [16:0] d, input int nbits);
    logic [15:0] w;
    w = d[15:0];
    if (nbits == 16 && w[15:11] == 5'd0 && !w[7] && !w[0]) begin
      m_word = w;
      m_bank[w[10:8]] = w[7:0];
    end
  endfunction

  task automatic send_bits(input logic [16:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      si = d[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_le();
    tick(4);
    le = 1'b1;
    tick(8);
    le = 1'b0;
    tick(8);
  endtask

  task automatic send_frame(input logic [16:0] d, input int n, output int dv, output int de);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_bits(d, n);
    pulse_le();
    dv = n_valid - v0;
    de = n_err - e0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_word"},  32'(word_o),  32'(m_word));
    check({tag, "_addr"},  32'(addr_o),  32'(m_word[10:8]));
    check({tag, "_value"}, 32'(value_o), 32'(m_word[7:0]));
    check({tag, "_gain"},  32'(gain_o),  32'(m_word[6:1]));
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      check($sformatf("%s_bank%0d", tag, a), 32'(bank_rd_data_o), 32'(m_bank[a]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    si = 1'b0; sclk = 1'b0; le = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    model_clear();
  endtask

  typedef struct {
    string       name;
    logic [16:0] data;
    int          nbits;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int dv, de, v0, e0, lat;
    logic [16:0] d;
    int nb;

    tbl[0] = '{"good_0554",  17'h00554, 16, 1, 0};
    tbl[1] = '{"short15",    17'h00312, 15, 0, 1};
    tbl[2] = '{"long17",     17'h00624, 17, 0, 1};
    tbl[3] = '{"pad_8554",   17'h08554, 16, 0, 1};
    tbl[4] = '{"val0_0555",  17'h00555, 16, 0, 1};
    tbl[5] = '{"val7_05d4",  17'h005d4, 16, 0, 1};
    tbl[6] = '{"zero_bits",  17'h00000, 0,  0, 1};
    tbl[7] = '{"good_0102",  17'h00102, 16, 1, 0};
    tbl[8] = '{"good_0204",  17'h00204, 16, 1, 0};

    // Reset state.
    do_reset();
    check_outputs("reset");
    check("reset_valid", 32'(word_valid_o), 32'd0);
    check("reset_err",   32'(frame_err_o),  32'd0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].data, tbl[i].nbits, dv, de);
      model_frame(tbl[i].data, tbl[i].nbits);
      check({tbl[i].name, "_nvalid"}, 32'(dv), 32'(tbl[i].exp_valid));
      check({tbl[i].name, "_nerr"},   32'(de), 32'(tbl[i].exp_err));
      check_outputs(tbl[i].name);
    end

    // Partial frame dropped by the idle timeout, then a full frame with latency measurement.
    v0 = n_valid;
    e0 = n_err;
    send_bits(17'h000ff, 8);
    tick(TO + 10);
    send_bits(17'h00312, 16);
    tick(4);
    le = 1'b1;
    lat = 99;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (word_valid_o) begin
        lat = n;
        break;
      end
    end
    tick(8);
    le = 1'b0;
    tick(8);
    model_frame(17'h00312, 16);
    check("timeout_latency", 32'(lat), 32'(SYNC + 2));
    check("timeout_nvalid",  32'(n_valid - v0), 32'd1);
    check("timeout_nerr",    32'(n_err - e0),   32'd0);
    check_outputs("timeout");

    // Randomized frames against the model.
    for (int i = 0; i < 40; i++) begin
      d = 17'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        d[15:11] = '0;
        d[7] = 1'b0;
        d[0] = 1'b0;
      end
      case ($urandom_range(0, 5))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      v0 = n_valid;
      e0 = n_err;
      send_frame(d, nb, dv, de);
      model_frame(d, nb);
      check($sformatf("rand%0d_nvalid", i), 32'(dv),
            32'((nb == 16 && d[15:11] == 5'd0 && !d[7] && !d[0]) ? 1 : 0));
      check($sformatf("rand%0d_npulse", i), 32'(dv + de), 32'd1);
      check($sformatf("rand%0d_word", i), 32'(word_o), 32'(m_word));
      rd_addr = d[10:8];
      #1;
      check($sformatf("rand%0d_bank", i), 32'(bank_rd_data_o), 32'(m_bank[d[10:8]]));
    end
    check_outputs("rand_end");

    // Back-to-back frames from a clean reset.
    do_reset();
    send_frame(17'h00102, 16, dv, de);
    model_frame(17'h00102, 16);
    check("b2b1_nvalid", 32'(dv), 32'd1);
    send_frame(17'h00204, 16, dv, de);
    model_frame(17'h00204, 16);
    check("b2b2_nvalid", 32'(dv), 32'd1);
    check_outputs("b2b");

    // Reset in the middle of a frame, then a full frame.
    v0 = n_valid;
    e0 = n_err;
    send_bits(17'h00555, 9);
    do_reset();
    check("midrst_npulse", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    check_outputs("midrst");
    send_frame(17'h00706, 16, dv, de);
    model_frame(17'h00706, 16);
    check("post_rst_nvalid", 32'(dv), 32'd1);
    check("post_rst_nerr",   32'(de), 32'd0);
    check_outputs("post_rst");

    check("never_both", 32'(n_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
